// File: rtl/data_mem_bank_if.sv
// Request/response bundle between the MEM stage and one data memory bank.
interface data_mem_bank_if #(parameter int ADDR_W = 10);
  logic              sel;
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              unsigned_ld;
  logic [ADDR_W+1:0] addr;
  logic [31:0]       d;
  logic              ready;
  logic [31:0]       q;
  logic              q_valid;
  logic              misalign;

  modport master (output sel, req, we, size, unsigned_ld, addr, d,
                  input  ready, q, q_valid, misalign);
  modport slave  (input  sel, req, we, size, unsigned_ld, addr, d,
                  output ready, q, q_valid, misalign);
endinterface

// File: rtl/data_mem_bank.sv
// RV32 data memory: four byte lanes, SB/SH/SW and LB/LH/LW/LBU/LHU sizing,
// registered load port, misalignment pulse and power-on clear sequencer.
module data_mem_lane #(parameter int ADDR_W = 10) (
  input  logic              clk,
  input  logic              wr,
  input  logic [ADDR_W-1:0] widx,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] ridx,
  output logic [7:0]        rdata
);
  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk)
    if (wr) mem[widx] <= wdata;

  assign rdata = mem[ridx];
endmodule

module data_mem_bank #(
  parameter int ADDR_W         = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  data_mem_bank_if.slave   bus
);
  localparam int NUM_LANES = 4;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                        state;
  logic [ADDR_W-1:0]             clr_idx;
  logic                          acc, mis, ld_acc;
  logic [ADDR_W-1:0]             widx, wr_idx;
  logic [NUM_LANES-1:0]          lane_wr;
  logic [NUM_LANES-1:0][7:0]     lane_wd, lane_rd;
  logic [7:0]                    rb;
  logic [15:0]                   rh;
  logic [31:0]                   ld_ext;

  assign bus.ready = (state == IDLE);
  assign acc       = bus.req & bus.sel & bus.ready;
  assign widx      = bus.addr[ADDR_W+1:2];
  assign wr_idx    = (state == CLEAR) ? clr_idx : widx;
  assign ld_acc    = acc & ~mis & ~bus.we;

  always_comb begin
    mis = 1'b0;
    case (bus.size)
      2'b01:   mis = bus.addr[0];
      2'b10:   mis = |bus.addr[1:0];
      2'b11:   mis = 1'b1;
      default: mis = 1'b0;
    endcase
  end

  // Clear sweep owns all lanes; otherwise only lanes covered by the store size.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_wr[l] = 1'b0;
      lane_wd[l] = 8'h00;
      if (state == CLEAR) begin
        lane_wr[l] = 1'b1;
      end else if (acc & bus.we & ~mis) begin
        case (bus.size)
          2'b00: begin
            lane_wr[l] = (bus.addr[1:0] == 2'(l));
            lane_wd[l] = bus.d[7:0];
          end
          2'b01: begin
            lane_wr[l] = (bus.addr[1] == l[1]);
            lane_wd[l] = l[0] ? bus.d[15:8] : bus.d[7:0];
          end
          default: begin
            lane_wr[l] = 1'b1;
            lane_wd[l] = bus.d[8*l +: 8];
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    data_mem_lane #(.ADDR_W(ADDR_W)) u_lane (
      .clk   (clk),
      .wr    (lane_wr[g]),
      .widx  (wr_idx),
      .wdata (lane_wd[g]),
      .ridx  (widx),
      .rdata (lane_rd[g])
    );
  end

  assign rb = lane_rd[bus.addr[1:0]];
  assign rh = bus.addr[1] ? lane_rd[3:2] : lane_rd[1:0];

  always_comb begin
    case (bus.size)
      2'b00:   ld_ext = bus.unsigned_ld ? {24'h0, rb} : {{24{rb[7]}}, rb};
      2'b01:   ld_ext = bus.unsigned_ld ? {16'h0, rh} : {{16{rh[15]}}, rh};
      default: ld_ext = lane_rd;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= CLEAR_ON_RESET ? CLEAR : IDLE;
      clr_idx      <= '0;
      bus.q        <= '0;
      bus.q_valid  <= 1'b0;
      bus.misalign <= 1'b0;
    end else begin
      bus.q_valid  <= ld_acc;
      bus.misalign <= acc & mis;
      if (ld_acc) bus.q <= ld_ext;
      if (state == CLEAR) begin
        clr_idx <= clr_idx + 1'b1;
        if (clr_idx == LAST) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_bank.sv
// Directed + random bench for data_mem_bank against a byte-array reference model.
module tb_data_mem_bank;
  localparam int AW    = 4;
  localparam int DEPTH = 2**AW;
  localparam int NB    = 4*DEPTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [7:0]  mref [NB];
  logic        mdl_ready = 1'b0;
  logic [31:0] exp_q = '0;

  data_mem_bank_if #(.ADDR_W(AW)) bus ();

  data_mem_bank #(.ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mload(input logic [5:0] a, input logic [1:0] sz, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    case (sz)
      2'd0: begin
        b = mref[a];
        return u ? {24'h0, b} : {{24{b[7]}}, b};
      end
      2'd1: begin
        h = {mref[a+6'd1], mref[a]};
        return u ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: return {mref[a+6'd3], mref[a+6'd2], mref[a+6'd1], mref[a]};
    endcase
  endfunction

  // Drive one cycle of bus inputs, advance one edge, then check the pulses it should cause.
  task automatic issue(input logic r, input logic s, input logic w, input logic [1:0] sz,
                       input logic u, input logic [5:0] a, input logic [31:0] dd);
    logic ac, m;
    bus.req = r; bus.sel = s; bus.we = w; bus.size = sz;
    bus.unsigned_ld = u; bus.addr = a; bus.d = dd;
    chk("ready", {31'h0, bus.ready}, {31'h0, mdl_ready});
    ac = r & s & mdl_ready;
    m  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    if (ac && !m && !w) exp_q = mload(a, sz, u);
    if (ac && !m && w) begin
      mref[a] = dd[7:0];
      if (sz != 2'd0) mref[a+6'd1] = dd[15:8];
      if (sz == 2'd2) begin
        mref[a+6'd2] = dd[23:16];
        mref[a+6'd3] = dd[31:24];
      end
    end
    @(posedge clk); #1;
    chk("q_valid", {31'h0, bus.q_valid}, {31'h0, ac & ~m & ~w});
    chk("misalign", {31'h0, bus.misalign}, {31'h0, ac & m});
    chk("q", bus.q, exp_q);
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 6'h0, 32'h0);
  endtask

  task automatic do_reset();
    bus.req = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_ready", {31'h0, bus.ready}, 32'h0);
    chk("rst_q", bus.q, 32'h0);
    chk("rst_qv", {31'h0, bus.q_valid}, 32'h0);
    chk("rst_mis", {31'h0, bus.misalign}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_ready = 1'b0;
    exp_q = '0;
    for (int i = 0; i < NB; i++) mref[i] = 8'h00;
  endtask

  task automatic clear_phase(input int cycles);
    // Requests during the sweep must be dropped; store attempts target word 0.
    for (int i = 0; i < cycles; i++) issue(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 6'h0, $urandom);
  endtask

  task automatic read_all();
    for (int w = 0; w < DEPTH; w++) issue(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 6'(4*w), 32'h0);
  endtask

  initial begin
    bus.sel = 0; bus.req = 0; bus.we = 0; bus.size = 0;
    bus.unsigned_ld = 0; bus.addr = '0; bus.d = '0;
    @(posedge clk); #1;

    // 1: reset, DEPTH clear cycles, memory reads zero
    do_reset();
    clear_phase(DEPTH);
    mdl_ready = 1'b1;
    read_all();

    // 2: word store then signed/unsigned byte and half loads
    issue(1, 1, 1, 2'd2, 0, 6'h10, 32'h8899AABB);
    issue(1, 1, 0, 2'd0, 0, 6'h13, 32'h0);
    chk("lb_const", bus.q, 32'hFFFFFF88);
    issue(1, 1, 0, 2'd0, 1, 6'h13, 32'h0);
    issue(1, 1, 0, 2'd1, 0, 6'h12, 32'h0);
    chk("lh_const", bus.q, 32'hFFFF8899);
    issue(1, 1, 0, 2'd1, 1, 6'h10, 32'h0);
    chk("lhu_const", bus.q, 32'h0000AABB);

    // 3: byte store leaves other lanes alone
    issue(1, 1, 1, 2'd0, 0, 6'h11, 32'hFFFFFF5A);
    issue(1, 1, 0, 2'd2, 0, 6'h10, 32'h0);
    chk("sb_merge", bus.q, 32'h88995ABB);

    // 4: misaligned / illegal requests
    issue(1, 1, 0, 2'd2, 0, 6'h02, 32'h0);
    issue(1, 1, 1, 2'd1, 0, 6'h05, 32'hDEADBEEF);
    issue(1, 1, 1, 2'd3, 0, 6'h04, 32'hCAFEF00D);
    idle();
    issue(1, 1, 0, 2'd2, 0, 6'h04, 32'h0);

    // 5: deselected request dropped; back-to-back loads
    issue(1, 0, 1, 2'd2, 0, 6'h20, 32'h12345678);
    issue(1, 1, 0, 2'd2, 0, 6'h20, 32'h0);
    issue(1, 1, 0, 2'd2, 0, 6'h10, 32'h0);
    issue(1, 1, 0, 2'd1, 0, 6'h12, 32'h0);
    idle();

    // Random traffic with a random mix of sizes, alignments, selects and idles
    for (int i = 0; i < 300; i++)
      issue($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
            2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, 6'($urandom), $urandom);
    for (int w = 0; w < DEPTH; w++) issue(1, 1, 1, 2'd2, 0, 6'(4*w), $urandom | 32'h1);

    // 6: reset at clr_idx=7 restarts the full sweep
    do_reset();
    clear_phase(7);
    do_reset();
    clear_phase(DEPTH);
    mdl_ready = 1'b1;
    read_all();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
